// File: rtl/cfg_pkg.sv
// Shared definitions for the IO configuration loader.
// Holds the loader state type, the default geometry of the configuration
// vector and the helper that derives the number of data words per load.
// The optional checksum word is enabled by defining CFG_CHECK_EN.
package cfg_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      COMMIT = 2'd2,
      DONE   = 2'd3
   } cfgState_t;

   localparam int CFG_NBITS = 15;
   localparam int CFG_WORD  = 8;

   // Number of WORD-bit words needed to cover an NBITS-wide vector (ceiling).
   function automatic int calcNWords(input int nbits, input int word);
      return (nbits + word - 1) / word;
   endfunction

   localparam int CFG_NWORDS = calcNWords(CFG_NBITS, CFG_WORD);
   localparam int CFG_CNT_W  = $clog2(CFG_NWORDS + 1);

endpackage

// File: rtl/cfg_shadow_reg.sv
// Shadow register for the IO configuration loader.
// Assembles incoming words into an NBITS-wide shadow at the slot selected by
// the word index; bits that would land at or above NBITS are dropped, so the
// top of the last word is padding. With CFG_CHECK_EN a running XOR of every
// accepted word (check word included) is kept, which is zero on a good load.
module cfg_shadow_reg
   import cfg_pkg::*;
#(
   parameter int NBITS  = CFG_NBITS,
   parameter int WORD   = CFG_WORD,
   parameter int CNT_W  = CFG_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clear,
   input  logic             i_write,
   input  logic [CNT_W-1:0] i_index,
   input  logic [WORD-1:0]  i_data,
`ifdef CFG_CHECK_EN
   output logic [WORD-1:0]  o_xorAcc,
`endif
   output logic [NBITS-1:0] o_shadow
);

   logic [NBITS-1:0] r_shadow;

   // Bit-wise placement: shadow bit b belongs to word b/WORD, lane b%WORD,
   // which keeps the write free of out-of-range slices for the padding bits.
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_shadow <= '0;
      end else if (i_write) begin
         for (int b = 0; b < NBITS; b++) begin
            if (i_index == CNT_W'(b / WORD)) begin
               r_shadow[b] <= i_data[b % WORD];
            end
         end
      end
   end

   assign o_shadow = r_shadow;

`ifdef CFG_CHECK_EN
   logic [WORD-1:0] r_xorAcc;

   // Running XOR over data words and the trailing check word of one load.
   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_xorAcc <= '0;
      end else if (i_write) begin
         r_xorAcc <= r_xorAcc ^ i_data;
      end
   end

   assign o_xorAcc = r_xorAcc;
`endif

endmodule

// File: rtl/io_config_loader.sv
// Serial-word configuration loader for the data IO block.
// Words arrive over a valid/ready handshake, are collected in a shadow
// register, and the whole vector is committed to c_out in a single edge so
// the IO muxes never see a half-written configuration.
// Optional checksum word and cfg_err port: define CFG_CHECK_EN.
module io_config_loader
   import cfg_pkg::*;
#(
   parameter int NBITS = CFG_NBITS,
   parameter int WORD  = CFG_WORD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_start,
   input  logic             cfg_valid,
   input  logic [WORD-1:0]  cfg_data,
   output logic             cfg_ready,
   output logic [NBITS-1:0] c_out,
   output logic             cfg_busy,
   output logic             cfg_done
`ifdef CFG_CHECK_EN
   ,
   output logic             cfg_err
`endif
);

   localparam int NWORDS = calcNWords(NBITS, WORD);
   localparam int CNT_W  = $clog2(NWORDS + 1);
`ifdef CFG_CHECK_EN
   localparam int LAST   = NWORDS;
`else
   localparam int LAST   = NWORDS - 1;
`endif
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LAST);

   cfgState_t        r_state;
   logic [CNT_W-1:0] r_count;
   logic [NBITS-1:0] r_cOut;
   logic             r_ready;
   logic             r_busy;
   logic             r_done;
   logic             w_hs;
   logic [NBITS-1:0] w_shadow;
`ifdef CFG_CHECK_EN
   logic             r_err;
   logic [WORD-1:0]  w_xorAcc;
`endif

   // r_ready is only ever high in LOAD, so it doubles as the state qualifier.
   // A start pulse beats a simultaneous word, which is therefore dropped.
   assign w_hs = r_ready && cfg_valid && !cfg_start;

   cfg_shadow_reg #(
      .NBITS (NBITS),
      .WORD  (WORD),
      .CNT_W (CNT_W)
   ) u_shadow (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (cfg_start),
      .i_write  (w_hs),
      .i_index  (r_count),
      .i_data   (cfg_data),
`ifdef CFG_CHECK_EN
      .o_xorAcc (w_xorAcc),
`endif
      .o_shadow (w_shadow)
   );

   // Load sequencing, word counting and the atomic commit, with all status
   // outputs registered alongside the state so they change with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_count <= '0;
         r_cOut  <= '0;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
`ifdef CFG_CHECK_EN
         r_err   <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (cfg_start) begin
                  r_state <= LOAD;
                  r_count <= '0;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
`ifdef CFG_CHECK_EN
                  r_err   <= 1'b0;
`endif
               end
            end
            LOAD: begin
               if (cfg_start) begin
                  r_count <= '0;
                  r_done  <= 1'b0;
`ifdef CFG_CHECK_EN
                  r_err   <= 1'b0;
`endif
               end else if (w_hs) begin
                  r_count <= r_count + CNT_W'(1);
                  if (r_count == LAST_IDX) begin
                     r_state <= COMMIT;
                     r_ready <= 1'b0;
                  end
               end
            end
            COMMIT: begin
`ifdef CFG_CHECK_EN
               if (w_xorAcc == '0) begin
                  r_cOut <= w_shadow;
                  r_done <= 1'b1;
               end else begin
                  r_done <= 1'b0;
                  r_err  <= 1'b1;
               end
`else
               r_cOut <= w_shadow;
               r_done <= 1'b1;
`endif
               // A start arriving now lets the commit land, then reloads.
               if (cfg_start) begin
                  r_state <= LOAD;
                  r_count <= '0;
                  r_ready <= 1'b1;
                  r_done  <= 1'b0;
`ifdef CFG_CHECK_EN
                  r_err   <= 1'b0;
`endif
               end else begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_ready <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign cfg_ready = r_ready;
   assign cfg_busy  = r_busy;
   assign cfg_done  = r_done;
   assign c_out     = r_cOut;
`ifdef CFG_CHECK_EN
   assign cfg_err   = r_err;
`endif

endmodule

// File: tb/tb_io_config_loader.sv
// Self-checking bench for io_config_loader.
// A transaction-level model (queue of accepted words, phase variable) predicts
// every output after each clock; directed steps are followed by random traffic.
// Build with CFG_CHECK_EN defined to exercise the checksum variant.
module tb_io_config_loader;

   localparam int NBITS  = 15;
   localparam int WORD   = 8;
   localparam int NWORDS = (NBITS + WORD - 1) / WORD;
`ifdef CFG_CHECK_EN
   localparam int NXFER  = NWORDS + 1;
`else
   localparam int NXFER  = NWORDS;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             cfgStart;
   logic             cfgValid;
   logic [WORD-1:0]  cfgData;
   logic             cfgReady;
   logic [NBITS-1:0] cOut;
   logic             cfgBusy;
   logic             cfgDone;
`ifdef CFG_CHECK_EN
   logic             cfgErr;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model: 0 idle, 1 loading, 2 committing, 3 done
   int               mPhase = 0;
   logic [WORD-1:0]  mWords[$];
   logic [NBITS-1:0] mCout = '0;
   logic             mDone = 1'b0;
   logic             mErr  = 1'b0;

   io_config_loader dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_start (cfgStart),
      .cfg_valid (cfgValid),
      .cfg_data  (cfgData),
      .cfg_ready (cfgReady),
      .c_out     (cOut),
      .cfg_busy  (cfgBusy),
      .cfg_done  (cfgDone)
`ifdef CFG_CHECK_EN
      ,
      .cfg_err   (cfgErr)
`endif
   );

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic modelEnterLoad();
      mWords.delete();
      mDone  = 1'b0;
      mErr   = 1'b0;
      mPhase = 1;
   endtask

   task automatic modelCommit();
      logic [31:0]     value;
      logic [WORD-1:0] parity;
      value  = '0;
      parity = '0;
      for (int i = 0; i < NWORDS; i++) begin
         value  = value | (32'(mWords[i]) << (WORD * i));
         parity = parity ^ mWords[i];
      end
`ifdef CFG_CHECK_EN
      if (parity == mWords[NWORDS]) begin
         mCout = value[NBITS-1:0];
         mDone = 1'b1;
      end else begin
         mDone = 1'b0;
         mErr  = 1'b1;
      end
`else
      mCout = value[NBITS-1:0];
      mDone = 1'b1;
`endif
   endtask

   task automatic modelUpdate(input logic r, input logic s, input logic v, input logic [WORD-1:0] d);
      if (r) begin
         mPhase = 0;
         mWords.delete();
         mCout  = '0;
         mDone  = 1'b0;
         mErr   = 1'b0;
      end else begin
         case (mPhase)
            0, 3: if (s) modelEnterLoad();
            1: begin
               if (s) modelEnterLoad();
               else if (v) begin
                  mWords.push_back(d);
                  if (mWords.size() == NXFER) mPhase = 2;
               end
            end
            default: begin
               modelCommit();
               if (s) modelEnterLoad();
               else mPhase = 3;
            end
         endcase
      end
   endtask

   // Drive one cycle of inputs, advance the model across the edge, settle
   task automatic applyStimulus(input logic r, input logic s, input logic v, input logic [WORD-1:0] d);
      rst      = r;
      cfgStart = s;
      cfgValid = v;
      cfgData  = d;
      @(posedge clk);
      modelUpdate(r, s, v, d);
      #1;
   endtask

   task automatic checkOutput(input string tag);
      checkVal({tag, " ready"}, 32'(cfgReady), 32'(mPhase == 1));
      checkVal({tag, " busy"},  32'(cfgBusy),  32'(mPhase == 1 || mPhase == 2));
      checkVal({tag, " done"},  32'(cfgDone),  32'(mDone));
      checkVal({tag, " c_out"}, 32'(cOut),     32'(mCout));
`ifdef CFG_CHECK_EN
      checkVal({tag, " err"},   32'(cfgErr),   32'(mErr));
`endif
   endtask

   task automatic step(input logic r, input logic s, input logic v, input logic [WORD-1:0] d, input string tag);
      applyStimulus(r, s, v, d);
      checkOutput(tag);
   endtask

   // Sends the two data words and, in checksum builds, their XOR
   task automatic sendLoad(input logic [WORD-1:0] w0, input logic [WORD-1:0] w1, input string tag);
      step(1'b0, 1'b0, 1'b1, w0, {tag, " w0"});
      step(1'b0, 1'b0, 1'b1, w1, {tag, " w1"});
`ifdef CFG_CHECK_EN
      step(1'b0, 1'b0, 1'b1, w0 ^ w1, {tag, " chk"});
`endif
   endtask

   initial begin
      logic r, s, v;
      rst = 1'b1; cfgStart = 1'b0; cfgValid = 1'b0; cfgData = '0;

      // Reset, then a plain two-word load
      step(1'b1, 1'b0, 1'b0, 8'h00, "reset");
      checkVal("reset c_out", 32'(cOut), 32'h0);
      step(1'b0, 1'b1, 1'b0, 8'h00, "start");
      sendLoad(8'hA5, 8'h7F, "load1");
      step(1'b0, 1'b0, 1'b0, 8'h00, "load1 commit");
      checkVal("load1 final c_out", 32'(cOut), 32'h7FA5);
      checkVal("load1 final done", 32'(cfgDone), 32'h1);

      // Valid while idle has no effect
      step(1'b1, 1'b0, 1'b0, 8'h00, "reset2");
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 8'hFF, "idle valid");
      checkVal("idle c_out", 32'(cOut), 32'h0);
      checkVal("idle ready", 32'(cfgReady), 32'h0);

      // Restart mid-load drops the word accepted with the start pulse
      step(1'b0, 1'b1, 1'b0, 8'h00, "restart start");
      step(1'b0, 1'b0, 1'b1, 8'h11, "restart w11");
      step(1'b0, 1'b1, 1'b1, 8'h22, "restart w22");
      sendLoad(8'h33, 8'h44, "restart");
      checkVal("restart pre-commit c_out", 32'(cOut), 32'h0);
      step(1'b0, 1'b0, 1'b0, 8'h00, "restart commit");
      checkVal("restart final c_out", 32'(cOut), 32'h4433);

      // Reset in the middle of a reload deconfigures the fabric
      step(1'b0, 1'b1, 1'b0, 8'h00, "rstmid start");
      sendLoad(8'hA5, 8'h7F, "rstmid load");
      step(1'b0, 1'b0, 1'b0, 8'h00, "rstmid commit");
      step(1'b0, 1'b1, 1'b0, 8'h00, "rstmid restart");
      step(1'b0, 1'b0, 1'b1, 8'h01, "rstmid w01");
      step(1'b1, 1'b0, 1'b0, 8'h00, "rstmid reset");
      checkVal("rstmid c_out", 32'(cOut), 32'h0);
      checkVal("rstmid done", 32'(cfgDone), 32'h0);

      // Valid toggling: only handshaken cycles count
      step(1'b0, 1'b1, 1'b0, 8'h00, "toggle start");
      step(1'b0, 1'b0, 1'b1, 8'h0F, "toggle v1");
      step(1'b0, 1'b0, 1'b0, 8'h55, "toggle v0");
      step(1'b0, 1'b0, 1'b1, 8'h00, "toggle v1b");
`ifdef CFG_CHECK_EN
      step(1'b0, 1'b0, 1'b0, 8'hAA, "toggle v0b");
      step(1'b0, 1'b0, 1'b1, 8'h0F, "toggle chk");
`endif
      step(1'b0, 1'b0, 1'b0, 8'h00, "toggle commit");
      checkVal("toggle c_out", 32'(cOut), 32'h000F);

      // Start during commit: commit lands, then a new load begins
      step(1'b0, 1'b1, 1'b0, 8'h00, "cstart start");
      sendLoad(8'h3C, 8'h12, "cstart load");
      step(1'b0, 1'b1, 1'b0, 8'h00, "cstart commit");
      checkVal("cstart c_out", 32'(cOut), 32'h123C);
      checkVal("cstart ready", 32'(cfgReady), 32'h1);
      sendLoad(8'h01, 8'h02, "cstart reload");
      step(1'b0, 1'b0, 1'b0, 8'h00, "cstart recommit");

`ifdef CFG_CHECK_EN
      // Good check word commits, bad one leaves c_out and raises cfg_err
      step(1'b0, 1'b1, 1'b0, 8'h00, "chk start");
      step(1'b0, 1'b0, 1'b1, 8'hA5, "chk w0");
      step(1'b0, 1'b0, 1'b1, 8'h7F, "chk w1");
      step(1'b0, 1'b0, 1'b1, 8'hDA, "chk good");
      step(1'b0, 1'b0, 1'b0, 8'h00, "chk commit");
      checkVal("chk good c_out", 32'(cOut), 32'h7FA5);
      step(1'b0, 1'b1, 1'b0, 8'h00, "bad start");
      step(1'b0, 1'b0, 1'b1, 8'hA5, "bad w0");
      step(1'b0, 1'b0, 1'b1, 8'h7F, "bad w1");
      step(1'b0, 1'b0, 1'b1, 8'hDB, "bad chk");
      step(1'b0, 1'b0, 1'b0, 8'h00, "bad commit");
      checkVal("bad c_out", 32'(cOut), 32'h7FA5);
      checkVal("bad err", 32'(cfgErr), 32'h1);
      checkVal("bad done", 32'(cfgDone), 32'h0);
`endif

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         r = ($urandom % 80) == 0;
         s = ($urandom % 10) == 0;
         v = ($urandom % 3) != 0;
         step(r, s, v, 8'($urandom), "random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
